// File: rtl/adc_seg_scan_pkg.sv
// Shared display definitions: glyph table, special segment patterns, converter states.
package adc_seg_scan_pkg;

  localparam logic [7:0] SEG_DASH  = 8'h40;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  typedef enum logic [1:0] {
    CVT_IDLE  = 2'd0,
    CVT_SHIFT = 2'd1,
    CVT_DONE  = 2'd2
  } cvt_state_t;

  // Segment order {dp,g,f,e,d,c,b,a}, active-high; dp never lit.
  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    logic [7:0] s;
    case (nib)
      4'h0: s = 8'h3F;
      4'h1: s = 8'h06;
      4'h2: s = 8'h5B;
      4'h3: s = 8'h4F;
      4'h4: s = 8'h66;
      4'h5: s = 8'h6D;
      4'h6: s = 8'h7D;
      4'h7: s = 8'h07;
      4'h8: s = 8'h7F;
      4'h9: s = 8'h6F;
      4'hA: s = 8'h77;
      4'hB: s = 8'h7C;
      4'hC: s = 8'h39;
      4'hD: s = 8'h5E;
      4'hE: s = 8'h79;
      default: s = 8'h71;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/adc_seg_scan_bin2bcd_seq.sv
// Sequential double-dabble: start -> DATA_W shift cycles -> one done cycle; start is also
// accepted in the done cycle for back-to-back conversions. overflow = value needs > NUM_DIGITS.
module bin2bcd_seq #(
  parameter int DATA_W     = 8,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DATA_W-1:0]       bin,
  output logic                    busy,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    overflow
);
  import adc_seg_scan_pkg::*;

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  cvt_state_t        state;
  logic [DATA_W-1:0] sh_bin;
  logic [BCD_W-1:0]  sh_bcd;
  logic [BCD_W-1:0]  bcd_adj;
  logic [CNT_W-1:0]  cnt;
  logic              ovf;

  always_comb begin
    bcd_adj = sh_bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sh_bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = sh_bcd[4*i +: 4] + 4'd3;
    end
  end

  // A bit leaving the top digit means that digit reached 10 or more: sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= CVT_IDLE;
      sh_bin <= '0;
      sh_bcd <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        CVT_IDLE, CVT_DONE: begin
          done <= 1'b0;
          if (start) begin
            state  <= CVT_SHIFT;
            sh_bin <= bin;
            sh_bcd <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
            busy   <= 1'b1;
          end else begin
            state <= CVT_IDLE;
            busy  <= 1'b0;
          end
        end
        CVT_SHIFT: begin
          sh_bcd <= {bcd_adj[BCD_W-2:0], sh_bin[DATA_W-1]};
          sh_bin <= sh_bin << 1;
          ovf    <= ovf | bcd_adj[BCD_W-1];
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state <= CVT_DONE;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= CVT_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign bcd      = sh_bcd;
  assign overflow = ovf;

endmodule

// File: rtl/adc_seg_scan.sv
// ADC sample averager feeding a multiplexed 7-segment scanner, hex or decimal display.
// Hex digits load 1 cycle after a request, decimal DATA_W+2 cycles; no backpressure on data_valid.
module adc_seg_scan #(
  parameter int DATA_W     = 8,
  parameter int NUM_DIGITS = 4,
  parameter int AVG_LOG2   = 2,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     data_in,
  input  logic                  data_valid,
  input  logic                  dec_mode,
  input  logic                  blank_en,
  output logic [7:0]            seg,
  output logic [NUM_DIGITS-1:0] dig_sel,
  output logic [DATA_W-1:0]     value_out,
  output logic                  value_stb
);
  import adc_seg_scan_pkg::*;

  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  // ---------------- averager ----------------
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic [CNT_W-1:0] smp_cnt;

  assign acc_sum = acc + ACC_W'(data_in);

  // With AVG_LOG2 = 0 the count stays at 0, so every sample completes a group.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      smp_cnt   <= '0;
      value_out <= '0;
      value_stb <= 1'b0;
    end else begin
      value_stb <= 1'b0;
      if (data_valid) begin
        if (smp_cnt == CNT_LAST) begin
          value_out <= DATA_W'(acc_sum >> AVG_LOG2);
          value_stb <= 1'b1;
          acc       <= '0;
          smp_cnt   <= '0;
        end else begin
          acc     <= acc_sum;
          smp_cnt <= smp_cnt + 1'b1;
        end
      end
    end
  end

  // ---------------- request / conversion ----------------
  logic             dec_mode_q;
  logic             req, dec_req, hex_req;
  logic             pending;
  logic             cvt_start, cvt_busy, cvt_done, cvt_ovf;
  logic [BCD_W-1:0] cvt_bcd;
  logic [BCD_W-1:0] dig_reg;
  logic             dig_dash;

  assign req     = value_stb | (dec_mode ^ dec_mode_q);
  assign dec_req = req & dec_mode;
  assign hex_req = req & ~dec_mode;
  // The done cycle doubles as a restart slot so a pending value never waits an idle cycle.
  assign cvt_start = (dec_req & ~cvt_busy) | (cvt_done & (pending | dec_req));

  bin2bcd_seq #(
    .DATA_W    (DATA_W),
    .NUM_DIGITS(NUM_DIGITS)
  ) u_cvt (
    .clk     (clk),
    .rst     (rst),
    .start   (cvt_start),
    .bin     (value_out),
    .busy    (cvt_busy),
    .done    (cvt_done),
    .bcd     (cvt_bcd),
    .overflow(cvt_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_mode_q <= 1'b0;
      pending    <= 1'b0;
      dig_reg    <= '0;
      dig_dash   <= 1'b0;
    end else begin
      dec_mode_q <= dec_mode;
      if (cvt_start || hex_req) pending <= 1'b0;
      else if (dec_req)         pending <= 1'b1;
      // A conversion finishing after a switch to hex must not overwrite the hex digits.
      if (hex_req) begin
        dig_reg  <= BCD_W'(value_out);
        dig_dash <= 1'b0;
      end else if (cvt_done && dec_mode) begin
        dig_reg  <= cvt_bcd;
        dig_dash <= cvt_ovf;
      end
    end
  end

  // ---------------- scan ----------------
  logic [PRE_W-1:0] pre;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [3:0]       nib;
  logic [BCD_W-1:0] upper;
  logic [7:0]       seg_nxt;

  always_comb begin
    idx_nxt = idx;
    if (pre == PRE_LAST) idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;
  end

  // Segments are computed for the slot being entered so seg and dig_sel move together.
  always_comb begin
    nib   = dig_reg[4*idx_nxt +: 4];
    upper = dig_reg >> (4*idx_nxt);
    if (dig_dash)
      seg_nxt = SEG_DASH;
    else if (blank_en && (idx_nxt != '0) && (upper == '0))
      seg_nxt = SEG_BLANK;
    else
      seg_nxt = hex_to_seg(nib);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre     <= '0;
      idx     <= '0;
      dig_sel <= NUM_DIGITS'(1);
      seg     <= hex_to_seg(4'h0);
    end else begin
      pre     <= (pre == PRE_LAST) ? '0 : pre + 1'b1;
      idx     <= idx_nxt;
      dig_sel <= NUM_DIGITS'(1) << idx_nxt;
      seg     <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_adc_seg_scan.sv
// Directed bench for adc_seg_scan with DATA_W=8, NUM_DIGITS=4, AVG_LOG2=2, SCAN_DIV=4.
module tb_adc_seg_scan;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       data_valid;
  logic       dec_mode;
  logic       blank_en;
  logic [7:0] seg;
  logic [3:0] dig_sel;
  logic [7:0] value_out;
  logic       value_stb;

  int n_cmp = 0;
  int n_bad = 0;
  int stb_cnt = 0;
  int start_cnt = 0;
  int s0, c0;

  adc_seg_scan #(
    .DATA_W    (8),
    .NUM_DIGITS(4),
    .AVG_LOG2  (2),
    .SCAN_DIV  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .data_valid(data_valid),
    .dec_mode  (dec_mode),
    .blank_en  (blank_en),
    .seg       (seg),
    .dig_sel   (dig_sel),
    .value_out (value_out),
    .value_stb (value_stb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (value_stb === 1'b1) stb_cnt++;
    if (dut.cvt_start === 1'b1) start_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic feed(input logic [7:0] v, input int n);
    data_valid = 1'b1;
    data_in    = v;
    tick(n);
    data_valid = 1'b0;
  endtask

  task automatic scan_chk(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                          input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] e [4];
    int k;
    e = '{e0, e1, e2, e3};
    k = 0;
    while (dig_sel !== 4'b0001 && k < 20) begin
      tick(1);
      k++;
    end
    chk($sformatf("%s_sync", tag), 32'(k < 20), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_sel%0d", tag, i), 32'(dig_sel), 32'(1 << i));
      chk($sformatf("%s_seg%0d", tag, i), 32'(seg), 32'(e[i]));
      tick(4);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; data_in = '0; data_valid = 1'b0; dec_mode = 1'b0; blank_en = 1'b0;
    tick(3);
    chk("rst_seg", 32'(seg), 32'h3F);
    chk("rst_sel", 32'(dig_sel), 32'h1);
    chk("rst_val", 32'(value_out), 32'h0);
    chk("rst_stb", 32'(value_stb), 32'h0);
    rst = 1'b0;

    // 10+11+12+13 = 46, 46>>2 = 11
    data_valid = 1'b1;
    data_in = 8'd10; tick(1);
    data_in = 8'd11; tick(1);
    data_in = 8'd12; tick(1);
    data_in = 8'd13; tick(1);
    data_valid = 1'b0;
    chk("avg_val", 32'(value_out), 32'd11);
    chk("avg_stb", 32'(value_stb), 32'd1);
    tick(1);
    chk("avg_stb_clr", 32'(value_stb), 32'd0);
    chk("avg_stb_cnt", 32'(stb_cnt), 32'd1);
    chk("hex_0b", 32'(dut.dig_reg), 32'h000B);

    // Hex A5, no blanking
    feed(8'hA5, 4);
    tick(2);
    scan_chk("hexA5", 8'h6D, 8'h77, 8'h3F, 8'h3F);

    // Mode change alone reconverts 165 without a strobe
    blank_en = 1'b1;
    s0 = stb_cnt;
    dec_mode = 1'b1;
    tick(12);
    chk("dec165", 32'(dut.dig_reg), 32'h0165);
    chk("tog_nostb", 32'(stb_cnt), 32'(s0));

    // 255 decimal: registers change exactly 10 cycles after the strobe
    feed(8'd255, 4);
    tick(9);
    chk("lat9", 32'(dut.dig_reg), 32'h0165);
    tick(1);
    chk("lat10", 32'(dut.dig_reg), 32'h0255);
    scan_chk("dec255", 8'h6D, 8'h6D, 8'h5B, 8'h00);

    // 100 starts conversion, 200 lands mid-conversion -> one restart
    c0 = start_cnt;
    feed(8'd100, 4);
    feed(8'd200, 4);
    tick(5);
    chk("rs_e9", 32'(dut.dig_reg), 32'h0255);
    tick(1);
    chk("rs_e10", 32'(dut.dig_reg), 32'h0100);
    tick(8);
    chk("rs_e18", 32'(dut.dig_reg), 32'h0100);
    tick(1);
    chk("rs_e19", 32'(dut.dig_reg), 32'h0200);
    tick(20);
    chk("rs_starts", 32'(start_cnt - c0), 32'd2);
    chk("rs_idle", 32'(dut.u_cvt.busy), 32'd0);

    // Zero with blanking: only digit 0 lit
    feed(8'd0, 4);
    tick(14);
    chk("zero_reg", 32'(dut.dig_reg), 32'h0000);
    scan_chk("zero", 8'h3F, 8'h00, 8'h00, 8'h00);

    // 32: decimal 0032, hex 0020, back to decimal via toggle only
    feed(8'd32, 4);
    tick(14);
    chk("d32", 32'(dut.dig_reg), 32'h0032);
    s0 = stb_cnt;
    c0 = start_cnt;
    dec_mode = 1'b0;
    tick(1);
    chk("h32", 32'(dut.dig_reg), 32'h0020);
    dec_mode = 1'b1;
    tick(10);
    chk("d32b", 32'(dut.dig_reg), 32'h0032);
    chk("tog_starts", 32'(start_cnt - c0), 32'd1);
    chk("tog_stb", 32'(stb_cnt), 32'(s0));

    // Reset with a conversion running and two samples of 77 accumulated
    feed(8'd99, 4);
    feed(8'd77, 2);
    s0 = stb_cnt;
    data_valid = 1'b1;
    data_in = 8'd77;
    rst = 1'b1;
    tick(1);
    chk("rst2_sel", 32'(dig_sel), 32'h1);
    chk("rst2_seg", 32'(seg), 32'h3F);
    chk("rst2_val", 32'(value_out), 32'h0);
    chk("rst2_stb", 32'(value_stb), 32'h0);
    chk("rst2_dig", 32'(dut.dig_reg), 32'h0);
    rst = 1'b0;
    data_valid = 1'b0;
    tick(6);
    chk("rst2_nostb", 32'(stb_cnt), 32'(s0));
    feed(8'd8, 4);
    tick(14);
    chk("rst2_avg", 32'(value_out), 32'd8);
    chk("rst2_stbcnt", 32'(stb_cnt), 32'(s0 + 1));
    chk("rst2_dec", 32'(dut.dig_reg), 32'h0008);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
